multdiv_scheduler: RTL and testbench
====================================

// Module: multdiv_scheduler
// PURPOSE
//  Sequences the shared multi-cycle mult/div unit for the 5-stage pipeline.
//  Accepts a mult/div from the X stage, pulses the unit's start control with latched operands, and tracks completion.
//  Arbitrates result writeback into the W-stage regfile port; raises the D-stage hazard stall.
//  Sits beside the X stage; replaces ad-hoc mult/div tracking in the pipeline stall logic.
// PARAMETERS
//  TIMEOUT     64  max BUSY cycles before forced abort (>=34)
//  CNT_W       7   counter width, 2^CNT_W > TIMEOUT
//  RSTATUS     30  register written on exception/abort
//  MULT_EXC    4   rstatus code for mult overflow/abort
//  DIV_EXC     5   rstatus code for div-by-zero/abort
// PORTS
//  clock         in   1   rising-edge clock
//  reset         in   1   asynchronous, active-high
//  FD_IR         in   32  D-stage instruction
//  DX_IR         in   32  X-stage instruction
//  DX_flush      in   1   X-stage instr squashed this cycle (no issue)
//  opA, opB      in   32  X-stage operand values
//  md_resultRDY  in   1   unit result valid (1-cycle pulse)
//  md_result     in   32  unit result
//  md_exception  in   1   unit exception, qualified by md_resultRDY
//  wb_ready      in   1   regfile write port free this cycle
//  ctrl_MULT     out  1   1-cycle start pulse, mult
//  ctrl_DIV      out  1   1-cycle start pulse, div
//  md_opA, md_opB out 32  operands latched at accept, stable until IDLE
//  md_busy       out  1   state != IDLE
//  stall         out  1   freeze PC/FD, bubble into DX
//  wb_en         out  1   writeback request/strobe
//  wb_rd         out  5   writeback register
//  wb_data       out  32  writeback value
// BEHAVIOUR
//  Decode: opcode=IR[31:27], aluop=IR[6:2], rd=[26:22], rs=[21:17], rt=[16:12].
//   isMD = opcode==00000 && aluop in {00110 mult, 00111 div}.
//  Reset: state=IDLE, counter=0; all outputs 0, md_opA/B=0.
//  FSM IDLE->ISSUE->BUSY->WB->IDLE:
//   IDLE:  DX isMD && !DX_flush -> latch opA/opB, rd, op type; ->ISSUE.
//   ISSUE: ctrl_MULT or ctrl_DIV =1 exactly this cycle; counter<=0; ->BUSY.
//   BUSY:  counter++ each cycle. md_resultRDY -> latch result/exc; ->WB.
//          counter==TIMEOUT-1 w/o RDY -> set exc (abort); ->WB.
//          RDY on the timeout cycle: RDY wins.
//   WB: wb_en=1; exc: wb_rd=RSTATUS, wb_data=MULT_EXC/DIV_EXC;
//       else wb_rd=rd, wb_data=result; rd==0 && !exc -> wb_en=0.
//       wb_ready=1 -> ->IDLE; else hold WB with wb_rd/wb_data stable.
//  Latency: DX accept -> ctrl pulse 1 cycle; RDY -> wb_en next cycle.
//  RDY outside BUSY: ignored. DX_flush outside IDLE: no effect (op committed).
//  New isMD in DX while not IDLE cannot occur (stall holds it in D).
//  stall (combinational):
//   pend_rd = IDLE ? DX rd : latched rd; pending = !IDLE || (DX isMD && !DX_flush).
//   stall = pending && ( (pend_rd!=0 && (FD rs==pend_rd || FD rt==pend_rd))
//           || FD isMD || (!IDLE && (FD rs==RSTATUS || FD rt==RSTATUS)) ).
//   Stays high through the WB accept cycle; drops the cycle after.
//  Widths: counter saturates, never wraps; no arithmetic on data paths.
//  Reset mid-operation: immediate IDLE, pulses/wb_en drop asynchronously;
//   unit result arriving later is ignored.
// STRUCTURE
//  Shared include multdiv_defs.vh: opcode/aluop encodings, IR field
//   positions, RSTATUS, exception codes, FSM state encodings.
//  Sub-module md_cycle_counter: CNT_W-bit counter, clr/en inputs, async reset,
//   terminal-count output. State and latch registers use existing dffe cells.
// TESTING
//  mult r3,r1,r2 (6*7); RDY after 17 cycles -> one ctrl_MULT, wb r3=42, wb_ready=1.
//  add r5,r3,r4 in D behind that mult -> stall=1 from DX accept to WB accept, then 0.
//  div with md_exception at RDY -> wb_rd=30, wb_data=5; rd untouched.
//  RDY never arrives -> abort at BUSY cycle 64, wb r30=4 (mult).
//  WB with wb_ready=0 for 3 cycles -> wb_en, wb_rd, wb_data held; IDLE after accept.
//  reset pulse in BUSY cycle 10; later RDY -> stays IDLE, no wb_en, stall=0.

Source files
------------

// File: rtl/multdiv_scheduler_pkg.sv
// Shared definitions for the mult/div scheduler:
// IR field decode, encodings, FSM states and defaults.
package multdiv_scheduler_pkg;

    localparam int MD_TIMEOUT  = 64;
    localparam int MD_CNT_W    = 7;
    localparam int MD_RSTATUS  = 30;
    localparam int MD_MULT_EXC = 4;
    localparam int MD_DIV_EXC  = 5;

    localparam logic [4:0] OP_ALU   = 5'b00000;
    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_WB    = 2'd3
    } md_state_t;

    function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
        return ir[31:27];
    endfunction

    function automatic logic [4:0] ir_rd(input logic [31:0] ir);
        return ir[26:22];
    endfunction

    function automatic logic [4:0] ir_rs(input logic [31:0] ir);
        return ir[21:17];
    endfunction

    function automatic logic [4:0] ir_rt(input logic [31:0] ir);
        return ir[16:12];
    endfunction

    function automatic logic [4:0] ir_aluop(input logic [31:0] ir);
        return ir[6:2];
    endfunction

    function automatic logic is_md(input logic [31:0] ir);
        return (ir_opcode(ir) == OP_ALU) &&
               ((ir_aluop(ir) == ALU_MULT) || (ir_aluop(ir) == ALU_DIV));
    endfunction

    function automatic logic is_div(input logic [31:0] ir);
        return ir_aluop(ir) == ALU_DIV;
    endfunction

endpackage

// File: rtl/multdiv_scheduler_md_cycle_counter.sv
// Saturating BUSY-cycle counter with clear/enable
// and a terminal-count flag for the abort timeout.
module md_cycle_counter
    import multdiv_scheduler_pkg::*;
#(
    parameter int CNT_W = MD_CNT_W,
    parameter int TERM  = MD_TIMEOUT - 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count;

    // Count up while enabled, hold at all-ones instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CNT_W'(TERM));

endmodule

// File: rtl/multdiv_scheduler.sv
// Issues X-stage mult/div ops to the shared unit, tracks
// completion/timeout, arbitrates writeback and raises D stall.
module multdiv_scheduler
    import multdiv_scheduler_pkg::*;
#(
    parameter int TIMEOUT  = MD_TIMEOUT,
    parameter int CNT_W    = MD_CNT_W,
    parameter int RSTATUS  = MD_RSTATUS,
    parameter int MULT_EXC = MD_MULT_EXC,
    parameter int DIV_EXC  = MD_DIV_EXC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] FD_IR,
    input  logic [31:0] DX_IR,
    input  logic        DX_flush,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        md_resultRDY,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        wb_ready,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        md_busy,
    output logic        stall,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    localparam logic [4:0]  RST_REG  = 5'(RSTATUS);
    localparam logic [31:0] MEXC_VAL = 32'(MULT_EXC);
    localparam logic [31:0] DEXC_VAL = 32'(DIV_EXC);

    md_state_t   state_q;
    md_state_t   state_d;
    logic [4:0]  rd_q;
    logic        div_q;
    logic [31:0] res_q;
    logic        exc_q;
    logic        tc;
    logic        idle;
    logic        accept;
    logic        pending;
    logic [4:0]  pend_rd;
    logic [4:0]  fd_rs;
    logic [4:0]  fd_rt;

    assign idle   = (state_q == S_IDLE);
    assign accept = idle && is_md(DX_IR) && !DX_flush;

    md_cycle_counter #(
        .CNT_W (CNT_W),
        .TERM  (TIMEOUT - 1)
    ) u_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (state_q == S_ISSUE),
        .en    (state_q == S_BUSY),
        .tc    (tc)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a ready result wins over the timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: state_d = S_BUSY;
            S_BUSY:  if (md_resultRDY || tc) state_d = S_WB;
            S_WB:    if (wb_ready) state_d = S_IDLE;
        endcase
    end

    // Operand/destination capture at accept, result capture in BUSY.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_opA <= '0;
            md_opB <= '0;
            rd_q   <= '0;
            div_q  <= 1'b0;
            res_q  <= '0;
            exc_q  <= 1'b0;
        end else if (accept) begin
            md_opA <= opA;
            md_opB <= opB;
            rd_q   <= ir_rd(DX_IR);
            div_q  <= is_div(DX_IR);
            exc_q  <= 1'b0;
        end else if (state_q == S_BUSY) begin
            if (md_resultRDY) begin
                res_q <= md_result;
                exc_q <= md_exception;
            end else if (tc) begin
                exc_q <= 1'b1;
            end
        end
    end

    // Start pulses, busy flag and writeback port drive.
    always_comb begin
        ctrl_MULT = (state_q == S_ISSUE) && !div_q;
        ctrl_DIV  = (state_q == S_ISSUE) && div_q;
        md_busy   = !idle;
        wb_en     = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        if (state_q == S_WB) begin
            wb_en = exc_q || (rd_q != '0);
            if (exc_q) begin
                wb_rd   = RST_REG;
                wb_data = div_q ? DEXC_VAL : MEXC_VAL;
            end else begin
                wb_rd   = rd_q;
                wb_data = res_q;
            end
        end
    end

    // D-stage hazard: RAW on the pending rd, a second
    // mult/div, or a read of rstatus while in flight.
    always_comb begin
        pend_rd = idle ? ir_rd(DX_IR) : rd_q;
        pending = !idle || accept;
        fd_rs   = ir_rs(FD_IR);
        fd_rt   = ir_rt(FD_IR);
        stall   = pending &&
                  (((pend_rd != '0) &&
                    ((fd_rs == pend_rd) || (fd_rt == pend_rd))) ||
                   is_md(FD_IR) ||
                   (!idle && ((fd_rs == RST_REG) || (fd_rt == RST_REG))));
    end

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Randomized self-checking bench for multdiv_scheduler
// against a transaction-level reference model.
module tb_multdiv_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] FD_IR;
    logic [31:0] DX_IR;
    logic        DX_flush;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        md_resultRDY;
    logic [31:0] md_result;
    logic        md_exception;
    logic        wb_ready;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] md_opA;
    logic [31:0] md_opB;
    logic        md_busy;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv_scheduler dut (
        .clock        (clock),
        .reset        (reset),
        .FD_IR        (FD_IR),
        .DX_IR        (DX_IR),
        .DX_flush     (DX_flush),
        .opA          (opA),
        .opB          (opB),
        .md_resultRDY (md_resultRDY),
        .md_result    (md_result),
        .md_exception (md_exception),
        .wb_ready     (wb_ready),
        .ctrl_MULT    (ctrl_MULT),
        .ctrl_DIV     (ctrl_DIV),
        .md_opA       (md_opA),
        .md_opB       (md_opB),
        .md_busy      (md_busy),
        .stall        (stall),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no end, expected end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op,
        input logic [4:0] rd, input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] alu);
        return {op, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic logic [31:0] mk_md(input bit div,
        input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return mk_ir(5'd0, rd, rs, rt, div ? 5'b00111 : 5'b00110);
    endfunction

    function automatic logic [31:0] noise_ir();
        logic [31:0] r;
        r = $urandom;
        r[31:27] = 5'b00101;
        return r;
    endfunction

    function automatic logic [31:0] rand_fd(input logic [4:0] rd);
        logic [4:0] o;
        o = 5'($urandom);
        case ($urandom_range(0, 4))
            0: return mk_ir(5'd0, o, rd, 5'd1, 5'd0);
            1: return mk_ir(5'd0, o, 5'd2, rd, 5'd0);
            2: return mk_ir(5'd0, o, 5'd30, 5'd2, 5'd0);
            3: return mk_md($urandom_range(0, 1) == 1, o, 5'd1, 5'd2);
            default: return $urandom;
        endcase
    endfunction

    // A D-stage instruction must wait if it reads the in-flight
    // destination, is itself a mult/div, or reads r30 while the
    // unit is occupied.
    function automatic bit exp_stall(input bit pend, input bit busy,
        input logic [4:0] prd, input logic [31:0] fd);
        logic [4:0] rs;
        logic [4:0] rt;
        bit reads_rd;
        bit fd_md;
        bit reads_r30;
        rs = fd[21:17];
        rt = fd[16:12];
        reads_rd  = (prd != 0) && (rs == prd || rt == prd);
        fd_md     = (fd[31:27] == 0) && (fd[6:2] == 6 || fd[6:2] == 7);
        reads_r30 = busy && (rs == 30 || rt == 30);
        return pend && (reads_rd || fd_md || reads_r30);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic run_txn(input bit div, input logic [4:0] rd,
        input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] res, input int rdy_at, input bit exc,
        input int wb_wait, input bit spur, input logic [31:0] fd0);
        int last;
        bit got_rdy;
        bit exc_eff;
        logic [4:0] erd;
        logic [31:0] edata;
        bit een;
        got_rdy = (rdy_at >= 1) && (rdy_at <= 64);
        last    = got_rdy ? rdy_at : 64;
        exc_eff = got_rdy ? exc : 1'b1;
        erd     = exc_eff ? 5'd30 : rd;
        edata   = exc_eff ? (div ? 32'd5 : 32'd4) : res;
        een     = exc_eff || (rd != 0);

        DX_IR = mk_md(div, rd, 5'($urandom), 5'($urandom));
        DX_flush = 1'b0;
        opA = a;
        opB = b;
        FD_IR = fd0;
        md_resultRDY = 1'b0;
        wb_ready = 1'($urandom);
        settle();
        check("idle_busy", md_busy, 0);
        check("idle_stall", stall, exp_stall(1, 0, rd, fd0));

        tick();
        DX_IR = noise_ir();
        DX_flush = 1'($urandom);
        opA = $urandom;
        opB = $urandom;
        md_resultRDY = spur;
        md_exception = 1'b1;
        md_result = $urandom;
        settle();
        check("issue_mult", ctrl_MULT, !div);
        check("issue_div", ctrl_DIV, div);
        check("issue_busy", md_busy, 1);
        check("issue_opA", md_opA, a);
        check("issue_opB", md_opB, b);
        check("issue_wb_en", wb_en, 0);
        check("issue_stall", stall, exp_stall(1, 1, rd, FD_IR));

        for (int c = 1; c <= last; c++) begin
            tick();
            FD_IR = rand_fd(rd);
            DX_IR = noise_ir();
            DX_flush = 1'($urandom);
            md_resultRDY = (c == rdy_at);
            md_exception = (c == rdy_at) ? exc : 1'($urandom);
            md_result = (c == rdy_at) ? res : $urandom;
            settle();
            check("busy_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
            check("busy_flag", md_busy, 1);
            check("busy_wb_en", wb_en, 0);
            check("busy_stall", stall, exp_stall(1, 1, rd, FD_IR));
        end
        check("busy_opA", md_opA, a);

        tick();
        for (int w = 0; w <= wb_wait; w++) begin
            wb_ready = (w == wb_wait);
            md_resultRDY = 1'($urandom);
            md_result = $urandom;
            md_exception = 1'($urandom);
            FD_IR = rand_fd(rd);
            settle();
            check("wb_en", wb_en, een);
            check("wb_rd", wb_rd, erd);
            check("wb_data", wb_data, edata);
            check("wb_busy", md_busy, 1);
            check("wb_stall", stall, exp_stall(1, 1, rd, FD_IR));
            tick();
        end

        DX_IR = noise_ir();
        md_resultRDY = 1'b0;
        FD_IR = rand_fd(rd);
        settle();
        check("post_busy", md_busy, 0);
        check("post_wb_en", wb_en, 0);
        check("post_stall", stall, 0);
    endtask

    task automatic run_flush();
        DX_IR = mk_md(1'($urandom), 5'd4, 5'd1, 5'd2);
        DX_flush = 1'b1;
        FD_IR = mk_ir(5'd0, 5'd6, 5'd4, 5'd4, 5'd0);
        settle();
        check("flush_stall", stall, 0);
        tick();
        DX_IR = noise_ir();
        DX_flush = 1'b0;
        settle();
        check("flush_busy", md_busy, 0);
        check("flush_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
    endtask

    task automatic run_reset();
        DX_IR = mk_md(1'b0, 5'd8, 5'd1, 5'd2);
        DX_flush = 1'b0;
        opA = 32'h1234;
        opB = 32'h5678;
        md_resultRDY = 1'b0;
        wb_ready = 1'b1;
        tick();
        DX_IR = noise_ir();
        for (int c = 1; c <= 10; c++) tick();
        FD_IR = mk_ir(5'd0, 5'd9, 5'd8, 5'd0, 5'd0);
        settle();
        check("rst_pre_busy", md_busy, 1);
        reset = 1'b1;
        settle();
        check("rst_async_busy", md_busy, 0);
        check("rst_async_wb", wb_en, 0);
        check("rst_async_stall", stall, 0);
        check("rst_async_opA", md_opA, 0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            md_resultRDY = (c == 3);
            md_result = 32'hbeef;
            settle();
            check("rst_late_busy", md_busy, 0);
            check("rst_late_wb", wb_en, 0);
            check("rst_late_stall", stall, 0);
            tick();
        end
        md_resultRDY = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        FD_IR = '0;
        DX_IR = '0;
        DX_flush = 1'b0;
        opA = '0;
        opB = '0;
        md_resultRDY = 1'b0;
        md_result = '0;
        md_exception = 1'b0;
        wb_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", md_busy, 0);
        check("rst_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
        check("rst_wb", {wb_en, wb_rd}, 0);
        check("rst_data", wb_data, 0);
        check("rst_opA", md_opA, 0);
        check("rst_opB", md_opB, 0);
        check("rst_stall", stall, 0);
        reset = 1'b0;
        tick();

        md_resultRDY = 1'b1;
        md_result = 32'h77;
        settle();
        tick();
        md_resultRDY = 1'b0;
        settle();
        check("idle_rdy_ignored", {md_busy, wb_en}, 0);

        run_txn(0, 5'd3, 32'd6, 32'd7, 32'd42, 17, 0, 0, 0,
                mk_ir(5'd0, 5'd5, 5'd3, 5'd4, 5'd0));
        run_txn(1, 5'd9, 32'd100, 32'd0, 32'hdead, 5, 1, 0, 0,
                mk_ir(5'd0, 5'd1, 5'd9, 5'd2, 5'd0));
        run_txn(0, 5'd12, 32'd3, 32'd4, 32'd12, 0, 0, 0, 0,
                mk_ir(5'd0, 5'd1, 5'd30, 5'd2, 5'd0));
        run_txn(0, 5'd14, 32'd2, 32'd9, 32'd18, 4, 0, 3, 0,
                mk_ir(5'd0, 5'd1, 5'd2, 5'd3, 5'd0));
        run_txn(1, 5'd7, 32'd50, 32'd5, 32'd10, 64, 0, 0, 0,
                mk_ir(5'd0, 5'd1, 5'd7, 5'd7, 5'd0));
        run_txn(1, 5'd0, 32'd9, 32'd3, 32'd3, 2, 0, 1, 1,
                mk_ir(5'd0, 5'd1, 5'd0, 5'd0, 5'd0));
        run_flush();

        for (int i = 0; i < 40; i++) begin
            int rdy;
            logic [4:0] rd;
            rd = 5'($urandom);
            if ($urandom_range(0, 7) == 0) rdy = 0;
            else if ($urandom_range(0, 7) == 0) rdy = $urandom_range(1, 64);
            else rdy = $urandom_range(1, 20);
            run_txn(1'($urandom), rd, $urandom, $urandom, $urandom, rdy,
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                    1'($urandom), rand_fd(rd));
            if ($urandom_range(0, 4) == 0) run_flush();
        end

        run_reset();
        run_txn(0, 5'd11, 32'd5, 32'd5, 32'd25, 3, 0, 0, 0,
                mk_ir(5'd0, 5'd1, 5'd11, 5'd2, 5'd0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
